// File: rtl/quadratic_solver_arbiter.sv
// Round-robin arbiter sharing one quadratic-root solver between two requesters.
// The winner's coefficients are latched on grant, the solver is started and
// watched with a timeout, and its result is routed back to the winning port.
//
// state | meaning
// IDLE  | sample requests, pick a winner, latch its coefficients
// ISSUE | grant and solver start pulse, timer cleared
// WAIT  | wait for solver done or timeout
// RESP  | done pulse to the owner, results already on its port
module quadratic_solver_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic signed [3:0] i_a0,
    input  logic signed [3:0] i_b0,
    input  logic signed [3:0] i_c0,
    input  logic signed [3:0] i_a1,
    input  logic signed [3:0] i_b1,
    input  logic signed [3:0] i_c1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [1:0]        o_status0,
    output logic [1:0]        o_status1,
    output logic signed [3:0] o_x1_0,
    output logic signed [3:0] o_x2_0,
    output logic signed [3:0] o_x1_1,
    output logic signed [3:0] o_x2_1,
    output logic              o_err0,
    output logic              o_err1,
    output logic              o_busy,
    output logic              o_slv_start,
    output logic signed [3:0] o_slv_a,
    output logic signed [3:0] o_slv_b,
    output logic signed [3:0] o_slv_c,
    input  logic              i_slv_done,
    input  logic [1:0]        i_slv_status,
    input  logic signed [3:0] i_slv_x1,
    input  logic signed [3:0] i_slv_x2
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       last;
    logic [7:0] timer;
    logic       win;
    logic       win_owner;
    logic       timeout_hit;

    // Timer value TIMEOUT_CYCLES-1 is reached in the last cycle allowed in WAIT.
    assign timeout_hit = (timer == 8'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and round-robin winner; on a tie the port that was not served last wins.
    always_comb begin
        state_nxt = state;
        win       = 1'b0;
        win_owner = 1'b0;
        case (state)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    win       = 1'b1;
                    win_owner = !(i_req0 && (!i_req1 || last));
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (i_slv_done || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, coefficient latch, timer and result capture; done beats timeout.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            owner       <= 1'b0;
            last        <= 1'b1;
            timer       <= '0;
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_done0     <= 1'b0;
            o_done1     <= 1'b0;
            o_status0   <= '0;
            o_status1   <= '0;
            o_x1_0      <= '0;
            o_x2_0      <= '0;
            o_x1_1      <= '0;
            o_x2_1      <= '0;
            o_err0      <= 1'b0;
            o_err1      <= 1'b0;
            o_busy      <= 1'b0;
            o_slv_start <= 1'b0;
            o_slv_a     <= '0;
            o_slv_b     <= '0;
            o_slv_c     <= '0;
        end else begin
            o_gnt0      <= win && !win_owner;
            o_gnt1      <= win && win_owner;
            o_slv_start <= win;
            o_done0     <= (state == WAIT) && (state_nxt == RESP) && !owner;
            o_done1     <= (state == WAIT) && (state_nxt == RESP) && owner;
            o_busy      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (win) begin
                        owner   <= win_owner;
                        o_slv_a <= win_owner ? i_a1 : i_a0;
                        o_slv_b <= win_owner ? i_b1 : i_b0;
                        o_slv_c <= win_owner ? i_c1 : i_c0;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (i_slv_done) begin
                        if (!owner) begin
                            o_status0 <= i_slv_status;
                            o_x1_0    <= i_slv_x1;
                            o_x2_0    <= i_slv_x2;
                            o_err0    <= 1'b0;
                        end else begin
                            o_status1 <= i_slv_status;
                            o_x1_1    <= i_slv_x1;
                            o_x2_1    <= i_slv_x2;
                            o_err1    <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        if (!owner) begin
                            o_status0 <= 2'b00;
                            o_x1_0    <= '0;
                            o_x2_0    <= '0;
                            o_err0    <= 1'b1;
                        end else begin
                            o_status1 <= 2'b00;
                            o_x1_1    <= '0;
                            o_x2_1    <= '0;
                            o_err1    <= 1'b1;
                        end
                    end
                end
                RESP:    last <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quadratic_solver_arbiter.sv
// Bench for quadratic_solver_arbiter: directed scenarios followed by random
// transactions, checked against a transaction-level model of arbitration,
// timing and per-port result routing.
module tb_quadratic_solver_arbiter;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
    logic       sdone = 1'b0;
    logic [1:0] sst = '0;
    logic [3:0] sx1 = '0, sx2 = '0;

    logic       gnt0, gnt1, done0, done1, err0, err1, busy, start;
    logic [1:0] st0, st1;
    logic [3:0] x1_0, x2_0, x1_1, x2_1, sa, sb, sc;

    quadratic_solver_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req0(req0), .i_req1(req1),
        .i_a0(a0), .i_b0(b0), .i_c0(c0), .i_a1(a1), .i_b1(b1), .i_c1(c1),
        .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
        .o_status0(st0), .o_status1(st1),
        .o_x1_0(x1_0), .o_x2_0(x2_0), .o_x1_1(x1_1), .o_x2_1(x2_1),
        .o_err0(err0), .o_err1(err1), .o_busy(busy), .o_slv_start(start),
        .o_slv_a(sa), .o_slv_b(sb), .o_slv_c(sc),
        .i_slv_done(sdone), .i_slv_status(sst), .i_slv_x1(sx1), .i_slv_x2(sx2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: which port was served last, and what each port shows.
    logic       m_last;
    logic [1:0] m_st [2];
    logic [3:0] m_x1 [2];
    logic [3:0] m_x2 [2];
    logic       m_err [2];

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        for (int p = 0; p < 2; p++) begin
            m_st[p] = '0; m_x1[p] = '0; m_x2[p] = '0; m_err[p] = 1'b0;
        end
    endtask

    task automatic check_ports(input string tag);
        chk({tag, "_status0"}, 4'(st0), 4'(m_st[0]));
        chk({tag, "_x1_0"}, x1_0, m_x1[0]);
        chk({tag, "_x2_0"}, x2_0, m_x2[0]);
        chk({tag, "_err0"}, 4'(err0), 4'(m_err[0]));
        chk({tag, "_status1"}, 4'(st1), 4'(m_st[1]));
        chk({tag, "_x1_1"}, x1_1, m_x1[1]);
        chk({tag, "_x2_1"}, x2_1, m_x2[1]);
        chk({tag, "_err1"}, 4'(err1), 4'(m_err[1]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {gnt0, gnt1, done0, done1}, 4'h0);
        chk({tag, "_busy_start"}, {2'b00, busy, start}, 4'h0);
        chk({tag, "_slv_a"}, sa, 4'h0);
        chk({tag, "_slv_b"}, sb, 4'h0);
        chk({tag, "_slv_c"}, sc, 4'h0);
        check_ports(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_idle_busy"}, 4'(busy), 4'h0);
            chk({tag, "_idle_ctl"}, {gnt0, gnt1, done0, done1}, 4'h0);
            check_ports(tag);
        end
    endtask

    // One transaction from request to response; the winner comes from the model.
    task automatic serve(input string tag, input int exp_wait, input int delay, input bit to,
                         input logic [1:0] st, input logic [3:0] x1, input logic [3:0] x2,
                         input bit keep);
        int own;
        int w;
        int r;
        bit got;
        logic [3:0] ea, eb, ec;
        own = (req0 && req1) ? int'(!m_last) : (req0 ? 0 : 1);
        w = 0;
        got = 1'b0;
        while (!got && w < 8) begin
            step();
            w++;
            if (gnt0 || gnt1) got = 1'b1;
        end
        chk({tag, "_grant_seen"}, 4'(got), 4'h1);
        if (!got) return;
        chk({tag, "_grant_wait"}, 4'(w), 4'(exp_wait));
        ea = own ? a1 : a0;
        eb = own ? b1 : b0;
        ec = own ? c1 : c0;
        chk({tag, "_gnt"}, {2'b00, gnt1, gnt0}, (own == 1) ? 4'h2 : 4'h1);
        chk({tag, "_start"}, 4'(start), 4'h1);
        chk({tag, "_busy"}, 4'(busy), 4'h1);
        chk({tag, "_slv_a"}, sa, ea);
        chk({tag, "_slv_b"}, sb, eb);
        chk({tag, "_slv_c"}, sc, ec);
        if (own == 0) begin
            a0 = 4'($urandom); b0 = 4'($urandom); c0 = 4'($urandom);
            if (!keep) req0 = 1'b0;
        end else begin
            a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom);
            if (!keep) req1 = 1'b0;
        end
        r = to ? T + 1 : delay + 1;
        for (int k = 1; k < r; k++) begin
            step();
            chk({tag, "_wait_ctl"}, {gnt0, gnt1, done0, done1}, 4'h0);
            chk({tag, "_wait_start"}, 4'(start), 4'h0);
            chk({tag, "_wait_busy"}, 4'(busy), 4'h1);
            chk({tag, "_wait_slv_a"}, sa, ea);
            sdone = !to && (k == delay);
            sst = st; sx1 = x1; sx2 = x2;
        end
        step();
        sdone = 1'b0;
        sst = 2'($urandom); sx1 = 4'($urandom); sx2 = 4'($urandom);
        m_st[own]  = to ? 2'b00 : st;
        m_x1[own]  = to ? 4'h0 : x1;
        m_x2[own]  = to ? 4'h0 : x2;
        m_err[own] = to;
        m_last     = 1'(own);
        chk({tag, "_done"}, {2'b00, done1, done0}, (own == 1) ? 4'h2 : 4'h1);
        chk({tag, "_resp_busy"}, 4'(busy), 4'h1);
        chk({tag, "_resp_slv"}, sb, eb);
        check_ports(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        check_zero("reset");
        idle("reset", 1);

        // Single request, A=1 B=-3 C=2, roots 2 and 1
        a0 = 4'd1; b0 = 4'hD; c0 = 4'd2; req0 = 1'b1;
        serve("basic", 1, 4, 1'b0, 2'b11, 4'd2, 4'd1, 1'b0);
        idle("basic", 1);

        // Tie right after reset: port 0 first, then port 1 (A=1 B=2 C=1, root -1)
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        check_zero("reset2");
        a0 = 4'($urandom); b0 = 4'($urandom); c0 = 4'($urandom);
        a1 = 4'd1; b1 = 4'd2; c1 = 4'd1;
        req0 = 1'b1; req1 = 1'b1;
        serve("tie0", 1, 2, 1'b0, 2'b11, 4'd3, 4'hE, 1'b0);
        serve("tie1", 2, 3, 1'b0, 2'b10, 4'hF, 4'hF, 1'b0);
        idle("tie", 1);

        // Both held: alternating grants, each transaction finishing before the next
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serve("rr", (i == 0) ? 1 : 2, $urandom_range(1, T), 1'b0, 2'($urandom),
                  4'($urandom), 4'($urandom), 1'b1);
            chk("rr_owner", 4'(m_last), 4'(i % 2));
        end
        req0 = 1'b0; req1 = 1'b0;
        idle("rr", 1);

        // Timeout, then a normal transaction
        req0 = 1'b1;
        serve("timeout", 1, 0, 1'b1, 2'b11, 4'd5, 4'd6, 1'b0);
        idle("timeout", 1);
        req1 = 1'b1;
        serve("after_to", 1, 2, 1'b0, 2'b01, 4'd0, 4'd0, 1'b0);
        idle("after_to", 1);

        // Done arriving in the very cycle the timeout would fire
        req0 = 1'b1;
        serve("coinc", 1, T, 1'b0, 2'b10, 4'd7, 4'd7, 1'b0);
        idle("coinc", 1);

        // Spurious solver done while idle
        sdone = 1'b1; sst = 2'b11; sx1 = 4'd4; sx2 = 4'd3;
        idle("spur", 1);
        sdone = 1'b0;
        idle("spur", 2);
        req1 = 1'b1;
        serve("post_spur", 1, 1, 1'b0, 2'b11, 4'd1, 4'h8, 1'b0);
        idle("post_spur", 1);

        // Reset during WAIT, late solver done ignored
        req1 = 1'b1;
        step();
        chk("mid_rst_gnt", {2'b00, gnt1, gnt0}, 4'h2);
        req1 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        check_zero("mid_rst");
        step();
        sdone = 1'b1; sst = 2'b11; sx1 = 4'd2; sx2 = 4'd2;
        step();
        sdone = 1'b0;
        check_zero("late_done");
        idle("late_done", 2);

        // Random transactions
        for (int i = 0; i < 12; i++) begin
            int rr;
            rr = int'($urandom_range(1, 3));
            a0 = 4'($urandom); b0 = 4'($urandom); c0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom);
            req0 = (rr & 1) != 0;
            req1 = (rr & 2) != 0;
            serve("rand", 1, $urandom_range(1, T), ($urandom_range(0, 4) == 0),
                  2'($urandom), 4'($urandom), 4'($urandom), 1'b0);
            req0 = 1'b0; req1 = 1'b0;
            idle("rand", 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/quadratic_solver_arbiter.md
# quadratic_solver_arbiter

Shares one quadratic-root solver datapath between two independent requesters (e.g. the switch/LED front panel and a self-test sequencer). It arbitrates round-robin, latches the winning requester's A/B/C coefficients, and sequences the solver through a start/done handshake with a timeout. It then routes the root status and roots back to the granted requester. The block sits between the requesters and the solver core, which is a multi-cycle unit that computes delta, its square root and the roots.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the request is aborted; legal range 2..255.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_req0, i_req1  in  1  request from requester 0 / 1; level, held until the matching o_gnt pulse.
- i_a0, i_b0, i_c0, i_a1, i_b1, i_c1  in  4  signed coefficients, range -8..7; valid while the request is high.
- o_gnt0, o_gnt1  out  1  one-cycle grant pulse; coefficients are latched on this cycle.
- o_done0, o_done1  out  1  one-cycle response pulse to the granted requester.
- o_status0, o_status1  out  2  root status: 00 not computed/aborted, 01 no roots, 10 repeated root, 11 two roots.
- o_x1_0, o_x2_0, o_x1_1, o_x2_1  out  4  signed roots per requester; held until that requester's next response.
- o_err0, o_err1  out  1  set with o_done when the request timed out; held like status.
- o_busy  out  1  high whenever the state is not IDLE.
- o_slv_start  out  1  one-cycle start pulse to the solver.
- o_slv_a, o_slv_b, o_slv_c  out  4  signed latched coefficients, stable from ISSUE through RESP.
- i_slv_done  in  1  solver completion pulse; sampled only in WAIT.
- i_slv_status  in  2  solver root status, valid with i_slv_done.
- i_slv_x1, i_slv_x2  in  4  signed solver roots, valid with i_slv_done.

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Outputs are Moore-style and registered.
- IDLE: requests are sampled here only.
  - If exactly one request is high, that requester wins.
  - If both are high, the requester that is not `last` wins.
  - On a win: latch the winner's A/B/C, record `owner`, go to ISSUE.
- ISSUE: o_gnt[owner]=1 and o_slv_start=1 for exactly one cycle; clear the timer; go to WAIT.
- WAIT: the timer increments every cycle.
  - If i_slv_done is high: capture status, x1 and x2; set err=0; go to RESP.
  - Else if the timer reaches TIMEOUT_CYCLES-1: set status=00, x1=x2=0, err=1; go to RESP.
  - If done and timeout coincide, done wins.
- RESP: o_done[owner]=1 for one cycle. In the same cycle, o_status/o_x1/o_x2/o_err[owner] take the captured values. Set `last`=owner; go to IDLE.
- Outputs of the non-owner port are untouched throughout.
- i_slv_done outside WAIT is ignored, so the solver must take at least 1 cycle after start.
- A request still high in IDLE after its own response is treated as a new request. Round-robin therefore alternates when both requesters stay high.
- Coefficient changes after the grant have no effect until the next grant.
- Reset: every output is 0, state is IDLE, timer is 0, `last`=1 (port 0 wins the first tie).
- Reset mid-operation aborts the transaction with no done pulse. A solver done arriving after reset is ignored.

## Timing
- Request sampled high at edge k → o_gnt and o_slv_start high in cycle k+1.
- Solver done sampled at edge m (in WAIT) → o_done and results in cycle m+1.
- Earliest next grant is 2 cycles after o_done (one IDLE sampling cycle, then ISSUE).
- Timeout: o_done occurs TIMEOUT_CYCLES+1 cycles after o_slv_start.
- o_busy rises one cycle after the winning request is sampled and falls the cycle after RESP.

## Test plan
- Port 0 requests A=1, B=-3, C=2; the solver model returns done 4 cycles after start with status 11, x1=2, x2=1 → o_gnt0 and o_slv_start together, o_slv_a/b/c=1/-3/2, then o_done0 with o_status0=11, o_x1_0=2, o_x2_0=1, o_err0=0; port 1 outputs stay 0.
- Both ports request simultaneously right after reset (port 1: A=1, B=2, C=1, solver returns 10, x1=x2=-1) → port 0 is served first, then o_gnt1; o_status1=10, o_x1_1=-1.
- Both requests held high for 4 transactions → grant order 0,1,0,1; no cycle overlap between transactions.
- Solver never asserts done, TIMEOUT_CYCLES=8 → o_done0 exactly 9 cycles after start with o_status0=00, o_err0=1, roots 0; the next request is served normally.
- i_rst_n low for 1 cycle during WAIT → all outputs 0 next cycle; a solver done arriving 2 cycles later produces no o_done.
- Spurious i_slv_done pulse in IDLE, and A changed after the grant → no response or state change; the solver still sees the latched A.
